svfloat_sign_arb: RTL and testbench
===================================

Name: svfloat_sign_arb

Overview:
- Shares one registered sign-manipulation datapath (pass / negate / absolute / force-negative) between N_REQ requesters.
- Round-robin arbitration with valid/ready handshakes per requester; one shared response channel tagged with requester ID.
- Sits between scalar FP issue ports and the FP register writeback in the svfloat library.
- Exponent and mantissa always pass through unmodified; only the sign bit is computed.

Parameters:
- float, svfloat::float32, floating-point type (sign/exponent/mantissa packed struct); W = $bits(float).
- N_REQ, 4, number of requesters, >=2.
- IDW, $clog2(N_REQ), width of the response ID (derived localparam, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- req_val  in  N_REQ x W  per-requester operand.
- req_op  in  N_REQ x 2  00 pass, 01 negate, 10 abs (sign:=0), 11 force negative (sign:=1).
- req_presv_nan  in  N_REQ  1 = keep the operand's sign unchanged when the operand is NaN.
- resp_valid  out  1  result register holds data.
- resp_ready  in  1  consumer accepts result.
- resp_res  out  W  result.
- resp_id  out  IDW  index of the requester that produced resp_res.

Behaviour:
- Reset (async, rst_n=0): resp_valid=0, resp_res=0, resp_id=0, RR pointer=0, req_ready=0 combinationally while in reset. Reset mid-transfer discards the held result; no response is emitted for it.
- NaN test: exponent all ones AND mantissa != 0. Infinities are not NaN.
- Sign rule: if req_presv_nan && NaN, then sign_out = sign_in; otherwise sign_out follows the op.
  - pass: sign_in.
  - negate: ~sign_in.
  - abs: 0.
  - force negative: 1.
- Output register "free" condition: !resp_valid || resp_ready.
- Arbitration: combinational, same cycle.
  - Search req_valid starting at index ptr, ascending with wrap; the first set bit wins.
  - req_ready[winner] = free; all other req_ready bits = 0.
  - If no request is valid, req_ready = 0.
- Accept = req_valid[w] && req_ready[w].
  - On accept: resp_res <= computed value, resp_id <= w, resp_valid <= 1, ptr <= (w+1) mod N_REQ. This applies even when N_REQ is not a power of two.
- No accept and resp_ready && resp_valid: resp_valid <= 0; resp_res and resp_id hold.
- Latency: 1 cycle from accept to resp_valid.
- Throughput: 1 per cycle while resp_ready=1. Simultaneous drain plus accept in the same cycle is allowed (back-to-back, no bubble).
- Stall (resp_valid && !resp_ready): resp_res and resp_id are stable; all req_ready = 0; ptr holds.
- ptr changes only on accept. A requester dropping req_valid before acceptance does not move ptr.
- Requesters must hold req_val, req_op and req_presv_nan stable while req_valid && !req_ready. The block does not check this.
- No combinational path from req_* to resp_*. req_ready depends combinationally on resp_ready, req_valid and ptr.

Optional Feature:
- Macro: SVFLOAT_SIGN_ARB_STATS_EN.
- Defined: adds output ports stat_accepts (32) and stat_stalls (32), both reset to 0.
  - stat_accepts increments on every accept.
  - stat_stalls increments each cycle with resp_valid && !resp_ready.
  - Both wrap modulo 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Single requester, float32: req 0 valid, val=0x3F800000, op=01, presv=0 -> next cycle resp_valid=1, resp_res=0xBF800000, resp_id=0.
- NaN preserve: val=0xFFC00000, op=10, presv=1 -> resp_res=0xFFC00000. Same with presv=0 -> 0x7FC00000. Val=0xFF800000 (-inf), op=10, presv=1 -> 0x7F800000.
- Round-robin fairness: all 4 requests held valid with resp_ready=1 for 8 cycles -> resp_id sequence 0,1,2,3,0,1,2,3; one accept per cycle, no bubbles.
- Backpressure: resp_ready=0 for 3 cycles with result 0xC0000000 held -> resp_res/resp_id stable; req_ready=0 throughout; stat_stalls +3 (when enabled). Then resp_ready=1 -> drain and next accept in the same cycle.
- Pointer hold: ptr=2, only req 0 valid -> grant 0, ptr=1. Next, reqs 0 and 3 valid -> grant 3.
- Async reset while resp_valid=1: assert rst_n=0 mid-cycle -> resp_valid=0 immediately. After release, reqs 1 and 2 valid -> first grant is 1 (ptr=0).

Source files
------------

// File: rtl/svfloat.sv
// svfloat library package: scalar floating-point storage types.
// Field names (sign/exp/man) are shared by every width.
package svfloat;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
  } float32;

  typedef struct packed {
    logic        sign;
    logic [10:0] exp;
    logic [51:0] man;
  } float64;

endpackage

// File: rtl/svfloat_sign_arb.sv
// Round-robin shared sign unit (pass/neg/abs/force-neg), 1-cycle latency.
// Optional counters: define SVFLOAT_SIGN_ARB_STATS_EN.
module svfloat_sign_arb #(
  parameter type float = svfloat::float32,
  parameter int N_REQ = 4,
  localparam int W = $bits(float),
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0][W-1:0] req_val,
  input  logic [N_REQ-1:0][1:0]   req_op,
  input  logic [N_REQ-1:0]        req_presv_nan,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [W-1:0]            resp_res,
  output logic [IDW-1:0]          resp_id
`ifdef SVFLOAT_SIGN_ARB_STATS_EN
  ,
  output logic [31:0]             stat_accepts,
  output logic [31:0]             stat_stalls
`endif
);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] ptr_nxt;
  logic           found;
  logic           free;
  logic           accept;
  int             idx;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(ptr) + i) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  assign free   = !resp_valid || resp_ready;
  assign accept = found && free && rst_n;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  // Wrap explicitly so non-power-of-two N_REQ never
  // lands the pointer on a requester that does not exist.
  assign ptr_nxt = (win == IDW'(N_REQ - 1)) ? '0
                 : win + 1'b1;

  float       op_f;
  float       res_d;
  logic [1:0] sel_op;
  logic       sel_presv;
  logic       is_nan;
  logic       sign_new;

  assign op_f      = req_val[win];
  assign sel_op    = req_op[win];
  assign sel_presv = req_presv_nan[win];
  assign is_nan    = (&op_f.exp) && (|op_f.man);

  always_comb begin
    sign_new = op_f.sign;
    if (!(sel_presv && is_nan)) begin
      unique case (sel_op)
        2'b00: sign_new = op_f.sign;
        2'b01: sign_new = ~op_f.sign;
        2'b10: sign_new = 1'b0;
        2'b11: sign_new = 1'b1;
        default: sign_new = op_f.sign;
      endcase
    end
  end

  always_comb begin
    res_d      = op_f;
    res_d.sign = sign_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_res   <= '0;
      resp_id    <= '0;
      ptr        <= '0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_res   <= res_d;
      resp_id    <= win;
      ptr        <= ptr_nxt;
    end else if (resp_valid && resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

`ifdef SVFLOAT_SIGN_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_accepts <= '0;
      stat_stalls  <= '0;
    end else begin
      if (accept)
        stat_accepts <= stat_accepts + 32'd1;
      if (resp_valid && !resp_ready)
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_svfloat_sign_arb.sv
// Bench for svfloat_sign_arb: transaction-level model checked
// every cycle, plus directed vectors with literal results.
module tb_svfloat_sign_arb;

  localparam int N = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0][31:0] req_val;
  logic [N-1:0][1:0]  req_op;
  logic [N-1:0]    req_presv_nan;
  logic            resp_valid;
  logic            resp_ready;
  logic [31:0]     resp_res;
  logic [1:0]      resp_id;
`ifdef SVFLOAT_SIGN_ARB_STATS_EN
  logic [31:0]     stat_accepts;
  logic [31:0]     stat_stalls;
`endif

  int errors = 0;
  int checks = 0;

  svfloat_sign_arb #(.N_REQ(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_val       (req_val),
    .req_op        (req_op),
    .req_presv_nan (req_presv_nan),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_res      (resp_res),
    .resp_id       (resp_id)
`ifdef SVFLOAT_SIGN_ARB_STATS_EN
    ,
    .stat_accepts  (stat_accepts),
    .stat_stalls   (stat_stalls)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish (got timeout, want $finish)");
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h @%0t", name, act, exp, $time);
    end
  endtask

  // Sign rule expressed on the IEEE bit pattern.
  function automatic logic [31:0] fexp(input logic [31:0] v,
                                       input logic [1:0] op,
                                       input logic presv);
    logic [7:0]  e;
    logic [22:0] m;
    e = v[30:23];
    m = v[22:0];
    if (presv && e == 8'hFF && m != 0) return v;
    case (op)
      2'd0: return v;
      2'd1: return v ^ 32'h8000_0000;
      2'd2: return v & 32'h7FFF_FFFF;
      default: return v | 32'h8000_0000;
    endcase
  endfunction

  // Model state: what the result register and pointer must hold.
  logic        m_valid;
  logic [31:0] m_res;
  int          m_id;
  int          m_ptr;
  int          m_acc;
  int          m_stall;

  initial begin
    logic [3:0] exp_rdy;
    logic       acc;
    logic       rr_s;
    int         w;
    logic [31:0] nres;
    m_valid = 0; m_res = 0; m_id = 0; m_ptr = 0;
    m_acc = 0; m_stall = 0;
    forever begin
      @(negedge clk);
      #4;
      acc = 1'b0; w = 0; exp_rdy = '0;
      rr_s = resp_ready;
      nres = 0;
      if (!rst_n) begin
        m_valid = 0; m_res = 0; m_id = 0; m_ptr = 0;
        m_acc = 0; m_stall = 0;
      end else if (!m_valid || resp_ready) begin
        for (int k = 0; k < N; k++) begin
          if (!acc && req_valid[(m_ptr + k) % N]) begin
            acc = 1'b1;
            w = (m_ptr + k) % N;
          end
        end
        if (acc) begin
          exp_rdy[w] = 1'b1;
          nres = fexp(req_val[w], req_op[w], req_presv_nan[w]);
        end
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      @(posedge clk);
      #1;
      if (!rst_n) begin
        m_valid = 0; m_res = 0; m_id = 0; m_ptr = 0;
        m_acc = 0; m_stall = 0;
      end else begin
        if (m_valid && !rr_s) m_stall++;
        if (acc) begin
          m_valid = 1; m_res = nres; m_id = w;
          m_ptr = (w + 1) % N;
          m_acc++;
        end else if (rr_s && m_valid) begin
          m_valid = 0;
        end
      end
      chk("resp_valid", 32'(resp_valid), 32'(m_valid));
      chk("resp_res", resp_res, m_res);
      chk("resp_id", 32'(resp_id), 32'(m_id));
`ifdef SVFLOAT_SIGN_ARB_STATS_EN
      chk("stat_accepts", stat_accepts, 32'(m_acc));
      chk("stat_stalls", stat_stalls, 32'(m_stall));
`endif
    end
  end

  task automatic set_req(input int i, input logic [31:0] v,
                         input logic [1:0] op, input logic p);
    req_val[i]       = v;
    req_op[i]        = op;
    req_presv_nan[i] = p;
  endtask

  // One accept of requester i, then literal check of the result.
  task automatic one(input string name, input int i,
                     input logic [31:0] v, input logic [1:0] op,
                     input logic p, input logic [31:0] want);
    @(negedge clk);
    set_req(i, v, op, p);
    req_valid = 4'(1 << i);
    @(posedge clk);
    #2;
    chk({name, "_v"}, 32'(resp_valid), 32'd1);
    chk({name, "_res"}, resp_res, want);
    chk({name, "_id"}, 32'(resp_id), 32'(i));
    @(negedge clk);
    req_valid = '0;
  endtask

  initial begin
    logic [31:0] s0;
    rst_n = 1'b0;
    resp_ready = 1'b1;
    req_valid = 4'hF;
    req_val = '0;
    req_op = '0;
    req_presv_nan = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_res", resp_res, 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    one("neg1", 0, 32'h3F80_0000, 2'b01, 1'b0, 32'hBF80_0000);
    one("nanp", 0, 32'hFFC0_0000, 2'b10, 1'b1, 32'hFFC0_0000);
    one("nana", 0, 32'hFFC0_0000, 2'b10, 1'b0, 32'h7FC0_0000);
    one("infa", 0, 32'hFF80_0000, 2'b10, 1'b1, 32'h7F80_0000);
    one("forc", 3, 32'h4000_0000, 2'b11, 1'b0, 32'hC000_0000);

    // ptr is 0 now; all four held valid for eight cycles
    @(negedge clk);
    for (int i = 0; i < N; i++)
      set_req(i, 32'h4100_0000 + 32'(i), 2'(i), 1'b0);
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #2;
      chk("rr_id", 32'(resp_id), 32'(c % N));
      chk("rr_v", 32'(resp_valid), 32'd1);
    end
    @(negedge clk);
    req_valid = '0;

    // backpressure on a 0xC0000000 result from requester 1
    @(negedge clk);
    set_req(1, 32'h4000_0000, 2'b01, 1'b0);
    req_valid = 4'b0010;
    @(posedge clk);
    #2;
    chk("bp_res0", resp_res, 32'hC000_0000);
`ifdef SVFLOAT_SIGN_ARB_STATS_EN
    s0 = stat_stalls;
`else
    s0 = 0;
`endif
    @(negedge clk);
    resp_ready = 1'b0;
    set_req(2, 32'h3F80_0000, 2'b00, 1'b0);
    req_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #3;
      chk("bp_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #2;
      chk("bp_res", resp_res, 32'hC000_0000);
      chk("bp_id", 32'(resp_id), 32'd1);
      @(negedge clk);
    end
`ifdef SVFLOAT_SIGN_ARB_STATS_EN
    chk("bp_stalls", stat_stalls - s0, 32'd3);
`endif
    resp_ready = 1'b1;
    #3;
    chk("bp_grant", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #2;
    chk("bp_next_v", 32'(resp_valid), 32'd1);
    chk("bp_next_res", resp_res, 32'h3F80_0000);
    chk("bp_next_id", 32'(resp_id), 32'd2);
    @(negedge clk);
    req_valid = '0;

    // ptr=3 -> accept 1 -> ptr=2; only 0 valid -> grant 0
    one("ph1", 1, 32'h0000_0001, 2'b00, 1'b0, 32'h0000_0001);
    one("ph0", 0, 32'h8000_0001, 2'b10, 1'b0, 32'h0000_0001);
    @(negedge clk);
    set_req(3, 32'h7F80_0000, 2'b01, 1'b1);
    req_valid = 4'b1001;
    resp_ready = 1'b0;
    @(posedge clk);
    #2;
    chk("ph3_id", 32'(resp_id), 32'd3);
    chk("ph3_res", resp_res, 32'hFF80_0000);
    @(negedge clk);
    req_valid = '0;

    // async reset while holding a stalled result
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_v", 32'(resp_valid), 32'd0);
    chk("arst_res", resp_res, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    set_req(1, 32'h3F80_0000, 2'b11, 1'b0);
    set_req(2, 32'h4000_0000, 2'b00, 1'b0);
    req_valid = 4'b0110;
    @(posedge clk);
    #2;
    chk("arst_id", 32'(resp_id), 32'd1);
    chk("arst_res1", resp_res, 32'hBF80_0000);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
